// File: rtl/per_ctrl_pkg.sv
// rtl/per_ctrl_pkg.sv - shared SPI master FSM state type and default frame constants
package per_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  localparam int SPI_DATA_W_DEF = 24;
  localparam int SPI_DIV_DEF    = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK half-period counter, CPOL=0 clock flop and edge strobes
module spi_sclk_gen #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic       sclk_q;
  logic       tc;

  // Strobes mark the clk_100m edge on which sclk_q is about to toggle.
  assign tc     = en_i && (cnt_q == DIV_M1);
  assign rise_o = tc && !sclk_q;
  assign fall_o = tc && sclk_q;
  assign sclk_o = sclk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else if (tc) begin
      cnt_q  <= 8'd0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/per_spi_master.sv
// rtl/per_spi_master.sv - single-frame SPI master, mode 0, MSB first, fixed SCLK divider
module per_spi_master
  import per_ctrl_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int DIV    = SPI_DIV_DEF
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int            BW       = $clog2(DATA_W);
  localparam logic [7:0]    DIV_M1   = 8'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_e        state_q;
  logic [7:0]        ph_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-2:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              sclk_rise;
  logic              sclk_fall;

  spi_sclk_gen #(
    .DIV (DIV)
  ) u_sclk_gen (
    .clk_i  (clk_100m),
    .rst_ni (rst_n),
    .en_i   (state_q == SHIFT),
    .sclk_o (spi_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ph_cnt_q   <= 8'd0;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            // The MSB goes straight to the pin; only the remaining bits are queued.
            tx_sh_q   <= tx_data[DATA_W-2:0];
            mosi_q    <= tx_data[DATA_W-1];
            cs_n_q    <= 1'b0;
            ph_cnt_q  <= 8'd0;
            bit_cnt_q <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (ph_cnt_q == DIV_M1) begin
            ph_cnt_q <= 8'd0;
            state_q  <= SHIFT;
          end else begin
            ph_cnt_q <= ph_cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_sh_q <= {rx_sh_q[DATA_W-2:0], spi_miso};
          end
          if (sclk_fall) begin
            // Zeros fill from the bottom, so MOSI rests low after the last bit.
            mosi_q  <= tx_sh_q[DATA_W-2];
            tx_sh_q <= {tx_sh_q[DATA_W-3:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= HOLD;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        HOLD: begin
          if (ph_cnt_q == DIV_M1) begin
            ph_cnt_q   <= 8'd0;
            cs_n_q     <= 1'b1;
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            state_q    <= GAP;
          end else begin
            ph_cnt_q <= ph_cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (ph_cnt_q == DIV_M1) begin
            ph_cnt_q <= 8'd0;
            state_q  <= IDLE;
          end else begin
            ph_cnt_q <= ph_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_per_spi_master.sv
// tb/tb_per_spi_master.sv - self-checking bench for per_spi_master at 24b/DIV2 and 8b/DIV1
module tb_per_spi_master;

  localparam int WA = 24;
  localparam int DA = 2;
  localparam int WB = 8;
  localparam int DB = 1;

  logic clk_100m = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic          tx_valid_a, tx_ready_a, rx_valid_a, busy_a;
  logic          sclk_a, cs_n_a, mosi_a, miso_a, loop_a, mconst_a;
  logic [WA-1:0] tx_data_a, rx_data_a;
  logic          tx_valid_b, tx_ready_b, rx_valid_b, busy_b;
  logic          sclk_b, cs_n_b, mosi_b, miso_b;
  logic [WB-1:0] tx_data_b, rx_data_b;

  assign miso_a = loop_a ? mosi_a : mconst_a;
  assign miso_b = mosi_b;

  per_spi_master #(.DATA_W(WA), .DIV(DA)) dut_a (
    .clk_100m (clk_100m), .rst_n (rst_n),
    .tx_valid (tx_valid_a), .tx_ready (tx_ready_a), .tx_data (tx_data_a),
    .rx_data  (rx_data_a), .rx_valid (rx_valid_a), .busy (busy_a),
    .spi_sclk (sclk_a), .spi_cs_n (cs_n_a), .spi_mosi (mosi_a), .spi_miso (miso_a)
  );

  per_spi_master #(.DATA_W(WB), .DIV(DB)) dut_b (
    .clk_100m (clk_100m), .rst_n (rst_n),
    .tx_valid (tx_valid_b), .tx_ready (tx_ready_b), .tx_data (tx_data_b),
    .rx_data  (rx_data_b), .rx_valid (rx_valid_b), .busy (busy_b),
    .spi_sclk (sclk_b), .spi_cs_n (cs_n_b), .spi_mosi (mosi_b), .spi_miso (miso_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {tx_ready, busy, sclk, cs_n, mosi} for cycle t after accept (t<0 = idle).
  function automatic logic [4:0] exp_sig(input int t, input int w, input int div,
                                         input logic [31:0] d);
    int   s;
    logic sc, cs, mo;
    if (t < 0) return 5'b10010;
    s  = t - div;
    cs = (t >= 2*div + 2*w*div);
    sc = (s >= 0 && s < 2*w*div) ? ((s / div) % 2 == 1) : 1'b0;
    if (t < div)            mo = d[w-1];
    else if (s < 2*w*div)   mo = d[w-1-s/(2*div)];
    else                    mo = 1'b0;
    return {1'b0, 1'b1, sc, cs, mo};
  endfunction

  int          t_a = -1, t_b = -1;
  logic [31:0] d_a = '0, d_b = '0, rxh_a = '0, rxh_b = '0;

  always @(posedge clk_100m) begin
    if (!rst_n) begin
      t_a = -1; rxh_a = '0; t_b = -1; rxh_b = '0;
    end else begin
      if (t_a < 0) begin
        if (tx_valid_a) begin t_a = 0; d_a = 32'(tx_data_a); end
      end else begin
        t_a++;
        if (t_a == 2*DA + 2*WA*DA) rxh_a = loop_a ? d_a : (mconst_a ? 32'hFFFFFF : 32'h0);
        if (t_a == DA*(2*WA+3)) t_a = -1;
      end
      if (t_b < 0) begin
        if (tx_valid_b) begin t_b = 0; d_b = 32'(tx_data_b); end
      end else begin
        t_b++;
        if (t_b == 2*DB + 2*WB*DB) rxh_b = d_b;
        if (t_b == DB*(2*WB+3)) t_b = -1;
      end
    end
  end

  always @(negedge clk_100m) begin
    logic [4:0] ea, eb;
    ea = exp_sig(rst_n ? t_a : -1, WA, DA, d_a);
    eb = exp_sig(rst_n ? t_b : -1, WB, DB, d_b);
    chk("a_tx_ready", 32'(tx_ready_a), 32'(ea[4]));
    chk("a_busy",     32'(busy_a),     32'(ea[3]));
    chk("a_sclk",     32'(sclk_a),     32'(ea[2]));
    chk("a_cs_n",     32'(cs_n_a),     32'(ea[1]));
    chk("a_mosi",     32'(mosi_a),     32'(ea[0]));
    chk("a_rx_valid", 32'(rx_valid_a), 32'(rst_n && t_a == 2*DA + 2*WA*DA));
    chk("a_rx_data",  32'(rx_data_a),  rst_n ? rxh_a : 32'h0);
    chk("b_tx_ready", 32'(tx_ready_b), 32'(eb[4]));
    chk("b_busy",     32'(busy_b),     32'(eb[3]));
    chk("b_sclk",     32'(sclk_b),     32'(eb[2]));
    chk("b_cs_n",     32'(cs_n_b),     32'(eb[1]));
    chk("b_mosi",     32'(mosi_b),     32'(eb[0]));
    chk("b_rx_valid", 32'(rx_valid_b), 32'(rst_n && t_b == 2*DB + 2*WB*DB));
    chk("b_rx_data",  32'(rx_data_b),  rst_n ? rxh_b : 32'h0);
  end

  task automatic frame_a(input logic [WA-1:0] d, input logic lp, input logic mc,
                         output int cyc, output int rises, output int per,
                         output int rxv, output int mones);
    int   bound, last_rise;
    logic prev;
    loop_a = lp; mconst_a = mc;
    @(posedge clk_100m); #2;
    tx_data_a = d; tx_valid_a = 1'b1;
    bound = 0;
    do begin @(negedge clk_100m); bound++; end while (!tx_ready_a && bound < 50);
    @(posedge clk_100m); #2;
    tx_valid_a = 1'b0;
    cyc = 0; rises = 0; per = 0; rxv = 0; mones = 0; prev = 1'b0; last_rise = -1;
    while (cyc < 400) begin
      @(negedge clk_100m);
      if (tx_ready_a) break;
      if (sclk_a && !prev) begin
        if (last_rise >= 0 && per == 0) per = cyc - last_rise;
        last_rise = cyc;
        rises++;
      end
      prev = sclk_a;
      if (rx_valid_a) rxv++;
      if (mosi_a) mones++;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, rises, per, rxv, mones, gap, bound, last_rise;
    logic prev;
    tx_valid_a = 1'b0; tx_data_a = '0; loop_a = 1'b1; mconst_a = 1'b0;
    tx_valid_b = 1'b0; tx_data_b = '0;
    repeat (3) @(posedge clk_100m);
    @(negedge clk_100m);
    chk("rst_tx_ready", 32'(tx_ready_a), 32'd1);
    chk("rst_busy",     32'(busy_a),     32'd0);
    chk("rst_cs_n",     32'(cs_n_a),     32'd1);
    chk("rst_sclk",     32'(sclk_a),     32'd0);
    chk("rst_mosi",     32'(mosi_a),     32'd0);
    chk("rst_rx_data",  32'(rx_data_a),  32'd0);
    @(posedge clk_100m); #2;
    rst_n = 1'b1;

    frame_a(24'hA5C3F0, 1'b1, 1'b0, cyc, rises, per, rxv, mones);
    chk("loop_period",   32'(cyc),       32'd102);
    chk("loop_rises",    32'(rises),     32'd24);
    chk("loop_sclk_per", 32'(per),       32'd4);
    chk("loop_rxv",      32'(rxv),       32'd1);
    chk("loop_rx_data",  32'(rx_data_a), 32'hA5C3F0);

    frame_a(24'h000000, 1'b0, 1'b1, cyc, rises, per, rxv, mones);
    chk("ones_mosi_hi",  32'(mones),     32'd0);
    chk("ones_rx_data",  32'(rx_data_a), 32'hFFFFFF);
    chk("ones_period",   32'(cyc),       32'd102);

    loop_a = 1'b1;
    @(posedge clk_100m); #2;
    tx_data_a = 24'h000001; tx_valid_a = 1'b1;
    bound = 0;
    do begin @(negedge clk_100m); bound++; end while (!tx_ready_a && bound < 50);
    @(posedge clk_100m); #2;
    repeat (10) @(posedge clk_100m);
    #2 tx_data_a = 24'hFFFFFF;
    repeat (30) @(posedge clk_100m);
    #2 tx_data_a = 24'h800000;
    bound = 0;
    do begin @(negedge clk_100m); bound++; end while (!rx_valid_a && bound < 200);
    chk("b2b_rx1", 32'(rx_data_a), 32'h000001);
    gap = 0;
    while (cs_n_a && gap < 50) begin gap++; @(negedge clk_100m); end
    chk("b2b_gap", 32'(gap), 32'(DA + 1));
    @(posedge clk_100m); #2;
    tx_valid_a = 1'b0;
    bound = 0;
    do begin @(negedge clk_100m); bound++; end while (!tx_ready_a && bound < 200);
    chk("b2b_rx2", 32'(rx_data_a), 32'h800000);

    @(posedge clk_100m); #2;
    tx_data_a = 24'h123456; tx_valid_a = 1'b1;
    bound = 0;
    do begin @(negedge clk_100m); bound++; end while (!tx_ready_a && bound < 50);
    @(posedge clk_100m); #2;
    tx_valid_a = 1'b0;
    repeat (20) @(posedge clk_100m);
    @(negedge clk_100m);
    chk("mid_cs_active", 32'(cs_n_a), 32'd0);
    @(posedge clk_100m); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n",     32'(cs_n_a),     32'd1);
    chk("arst_sclk",     32'(sclk_a),     32'd0);
    chk("arst_rx_valid", 32'(rx_valid_a), 32'd0);
    rxv = 0;
    repeat (3) begin @(negedge clk_100m); if (rx_valid_a) rxv++; end
    chk("arst_no_rxv", 32'(rxv), 32'd0);
    @(posedge clk_100m); #2;
    rst_n = 1'b1;
    @(negedge clk_100m);
    chk("arst_tx_ready", 32'(tx_ready_a), 32'd1);
    frame_a(24'h5A0F96, 1'b1, 1'b0, cyc, rises, per, rxv, mones);
    chk("post_rst_period", 32'(cyc),       32'd102);
    chk("post_rst_rx",     32'(rx_data_a), 32'h5A0F96);

    @(posedge clk_100m); #2;
    tx_data_b = 8'h3C; tx_valid_b = 1'b1;
    bound = 0;
    do begin @(negedge clk_100m); bound++; end while (!tx_ready_b && bound < 50);
    @(posedge clk_100m); #2;
    tx_valid_b = 1'b0;
    cyc = 0; rises = 0; per = 0; prev = 1'b0; last_rise = -1;
    while (cyc < 100) begin
      @(negedge clk_100m);
      if (tx_ready_b) break;
      if (sclk_b && !prev) begin
        if (last_rise >= 0 && per == 0) per = cyc - last_rise;
        last_rise = cyc;
        rises++;
      end
      prev = sclk_b;
      cyc++;
    end
    chk("fast_period",   32'(cyc),       32'd19);
    chk("fast_rises",    32'(rises),     32'd8);
    chk("fast_sclk_per", 32'(per),       32'd2);
    chk("fast_rx_data",  32'(rx_data_b), 32'h3C);

    repeat (3) @(posedge clk_100m);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
